// File: rtl/mem_stage_if.sv
// mem_stage_if: execute->memory->write-back handshake and data bus for mem_stage
//   exe_to_mem_valid/exe_to_mem_data : upstream bundle (103 bits)
//   mem_allow                        : stage can accept a bundle
//   data_sram_rdata                  : synchronous SRAM read data
//   wb_allow                         : write-back can accept a bundle
//   mem_to_wb_valid/mem_to_wb_data   : downstream bundle (70 bits)
//   mem_wr, mem_fwd_data             : register-write tag and forwarded result
interface mem_stage_if;
  logic         exe_to_mem_valid;
  logic [102:0] exe_to_mem_data;
  logic         mem_allow;
  logic [31:0]  data_sram_rdata;
  logic         wb_allow;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_data;
  logic [5:0]   mem_wr;
  logic [31:0]  mem_fwd_data;
  modport master (
    output exe_to_mem_valid, exe_to_mem_data, data_sram_rdata, wb_allow,
    input  mem_allow, mem_to_wb_valid, mem_to_wb_data, mem_wr, mem_fwd_data
  );
  modport slave (
    input  exe_to_mem_valid, exe_to_mem_data, data_sram_rdata, wb_allow,
    output mem_allow, mem_to_wb_valid, mem_to_wb_data, mem_wr, mem_fwd_data
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage merging SRAM load data into the write-back bundle
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : mem_stage_if.slave (upstream bundle, SRAM read data, downstream bundle, wr tag, forward data)
module mem_stage (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave bus
);
  logic         mem_valid_q, mem_valid_d;
  logic         mem_first_q, mem_first_d;
  logic [31:0]  rdata_buf_q, rdata_buf_d;
  logic [102:0] payload_q, payload_d;
  logic         gr_we, res_from_mem;
  logic [4:0]   dest;
  logic [31:0]  pc, alu_result;
  logic [9:0]   op;
  logic [1:0]   a;
  logic [31:0]  raw_rdata, byte_sh, half_sh, load_value, final_result;
  logic         accept;
  assign {gr_we, res_from_mem, dest, pc} = payload_q[102:64];
  assign op         = payload_q[63:54];
  assign alu_result = payload_q[31:0];
  assign a          = alu_result[1:0];
  // SRAM data is only valid the cycle after acceptance; afterwards use the held copy
  assign raw_rdata = mem_first_q ? bus.data_sram_rdata : rdata_buf_q;
  assign byte_sh   = raw_rdata >> {a, 3'b000};
  assign half_sh   = raw_rdata >> {a[1], 4'b0000};
  always_comb begin
    load_value = op == 10'h0A0 ? {{24{byte_sh[7]}}, byte_sh[7:0]} :
                 op == 10'h0A1 ? {{16{half_sh[15]}}, half_sh[15:0]} :
                 op == 10'h0A8 ? {24'd0, byte_sh[7:0]} :
                 op == 10'h0A9 ? {16'd0, half_sh[15:0]} :
                 raw_rdata;
    final_result = res_from_mem ? load_value : alu_result;
  end
  assign bus.mem_to_wb_valid = mem_valid_q;
  assign bus.mem_allow       = ~mem_valid_q | (bus.mem_to_wb_valid & bus.wb_allow);
  assign bus.mem_to_wb_data  = {gr_we, dest, pc, final_result};
  assign bus.mem_wr          = {mem_valid_q & gr_we, dest};
  assign bus.mem_fwd_data    = final_result;
  assign accept              = bus.exe_to_mem_valid & bus.mem_allow;
  always_comb begin
    mem_valid_d = bus.mem_allow ? bus.exe_to_mem_valid : mem_valid_q;
    payload_d   = accept ? bus.exe_to_mem_data : payload_q;
    mem_first_d = accept;
    rdata_buf_d = mem_first_q ? bus.data_sram_rdata : rdata_buf_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      mem_first_q <= 1'b0;
      rdata_buf_q <= 32'd0;
      payload_q   <= 103'd0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_first_q <= mem_first_d;
      rdata_buf_q <= rdata_buf_d;
      payload_q   <= payload_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural model
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  mem_stage_if bus();
  mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  bit           occ = 0;
  logic [102:0] bund = '0;
  int           age = 0;
  logic [31:0]  lrd = '0;
  logic         seen_v, seen_allow;
  logic [5:0]   seen_wr;
  logic [31:0]  seen_fwd;
  task automatic chk(string tag, logic [69:0] got, logic [69:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_result(logic [102:0] b, logic [31:0] r);
    int unsigned alu, a, by, hw;
    alu = b[31:0];
    a   = alu % 4;
    by  = (r >> (8 * a)) % 256;
    hw  = (r >> (16 * (a / 2))) % 65536;
    if (!b[101]) return alu;
    case (b[63:54])
      10'h0A0: return by > 127 ? by - 256 : by;
      10'h0A1: return hw > 32767 ? hw - 65536 : hw;
      10'h0A8: return by;
      10'h0A9: return hw;
      default: return r;
    endcase
  endfunction
  function automatic logic [102:0] mk(bit we, bit rfm, logic [4:0] d, logic [31:0] pc,
                                      logic [9:0] op, logic [31:0] alu);
    logic [21:0] lo;
    lo = 22'($urandom);
    return {we, rfm, d, pc, op, lo, alu};
  endfunction
  function automatic logic [102:0] rand_bundle();
    logic [9:0] ops [6];
    ops = '{10'h0A0, 10'h0A1, 10'h0A2, 10'h0A8, 10'h0A9, 10'($urandom)};
    return mk(1'($urandom), 1'($urandom), 5'($urandom), $urandom, ops[$urandom_range(0, 5)], $urandom);
  endfunction
  task automatic cycle(bit v, logic [102:0] d, logic [31:0] rd, bit wa);
    logic [31:0] exp_res;
    bus.exe_to_mem_valid = v;
    bus.exe_to_mem_data  = d;
    bus.data_sram_rdata  = rd;
    bus.wb_allow         = wa;
    #3;
    if (occ && age == 1) lrd = rd;
    exp_res    = ref_result(bund, lrd);
    seen_v     = bus.mem_to_wb_valid;
    seen_allow = bus.mem_allow;
    seen_wr    = bus.mem_wr;
    seen_fwd   = bus.mem_fwd_data;
    chk("valid", 70'(bus.mem_to_wb_valid), 70'(occ));
    chk("allow", 70'(bus.mem_allow), 70'(!occ || wa));
    chk("wr", 70'(bus.mem_wr), 70'({occ & bund[102], bund[100:96]}));
    if (occ) begin
      chk("data", bus.mem_to_wb_data, {bund[102], bund[100:96], bund[95:64], exp_res});
      chk("fwd", 70'(bus.mem_fwd_data), 70'(exp_res));
    end
    @(posedge clk);
    if (!resetn) begin
      occ = 0; bund = '0; age = 0; lrd = '0;
    end else if (!occ || wa) begin
      occ = v;
      if (v) begin bund = d; age = 1; end else age++;
    end else age++;
    #1;
  endtask
  initial begin
    logic [102:0] b;
    bus.exe_to_mem_valid = 1'b0;
    bus.exe_to_mem_data  = '0;
    bus.data_sram_rdata  = '0;
    bus.wb_allow         = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    cycle(0, '0, '0, 1);
    chk("reset_valid", 70'(seen_v), 70'(0));
    chk("reset_wr", 70'(seen_wr), 70'(0));
    chk("reset_allow", 70'(seen_allow), 70'(1));
    // word load
    cycle(1, mk(1, 1, 5'd5, 32'h1c000000, 10'h0A2, 32'h1000), 32'h0, 1);
    cycle(0, '0, 32'hDEADBEEF, 1);
    chk("ldw_valid", 70'(seen_v), 70'(1));
    chk("ldw_res", 70'(seen_fwd), 70'(32'hDEADBEEF));
    chk("ldw_wr", 70'(seen_wr), 70'(6'h25));
    cycle(0, '0, 32'h0, 1);
    chk("ldw_once", 70'(seen_v), 70'(0));
    // byte/half loads, back to back
    cycle(1, mk(1, 1, 5'd1, 32'h100, 10'h0A0, 32'h3), 32'h0, 1);
    cycle(1, mk(1, 1, 5'd2, 32'h104, 10'h0A8, 32'h3), 32'h80123456, 1);
    chk("ldb", 70'(seen_fwd), 70'(32'hFFFFFF80));
    cycle(1, mk(1, 1, 5'd3, 32'h108, 10'h0A1, 32'h2), 32'h80123456, 1);
    chk("ldbu", 70'(seen_fwd), 70'(32'h00000080));
    cycle(1, mk(1, 1, 5'd4, 32'h10c, 10'h0A9, 32'h0), 32'h9ABC1234, 1);
    chk("ldh", 70'(seen_fwd), 70'(32'hFFFF9ABC));
    cycle(0, '0, 32'h9ABC1234, 1);
    chk("ldhu", 70'(seen_fwd), 70'(32'h00001234));
    // backpressure
    cycle(1, mk(1, 1, 5'd7, 32'h200, 10'h0A2, 32'h40), 32'h0, 1);
    cycle(0, '0, 32'h11111111, 0);
    chk("bp_res0", 70'(seen_fwd), 70'(32'h11111111));
    chk("bp_allow0", 70'(seen_allow), 70'(0));
    cycle(0, '0, 32'h22222222, 0);
    chk("bp_res1", 70'(seen_fwd), 70'(32'h11111111));
    chk("bp_allow1", 70'(seen_allow), 70'(0));
    cycle(0, '0, 32'h33333333, 0);
    chk("bp_res2", 70'(seen_fwd), 70'(32'h11111111));
    cycle(0, '0, 32'h44444444, 1);
    chk("bp_leave", 70'(seen_v), 70'(1));
    chk("bp_res3", 70'(seen_fwd), 70'(32'h11111111));
    cycle(0, '0, 32'h0, 1);
    chk("bp_once", 70'(seen_v), 70'(0));
    // throughput then bubble
    cycle(1, mk(1, 0, 5'd10, 32'h300, 10'h000, 32'hA0), 32'h0, 1);
    for (int i = 1; i < 5; i++) begin
      cycle(i < 4, mk(1, 0, 5'(10 + i), 32'h300 + 32'(4 * i), 10'h000, 32'hA0 + 32'(i)), 32'h0, 1);
      chk("tp_valid", 70'(seen_v), 70'(1));
      chk("tp_res", 70'(seen_fwd), 70'(32'hA0 + 32'(i - 1)));
    end
    cycle(0, '0, 32'h0, 1);
    chk("bubble_valid", 70'(seen_v), 70'(0));
    chk("bubble_wr5", 70'(seen_wr[5]), 70'(0));
    // reset mid-stall
    cycle(1, mk(1, 1, 5'd9, 32'h400, 10'h0A2, 32'h0), 32'h0, 1);
    cycle(0, '0, 32'h55555555, 0);
    resetn = 1'b0;
    cycle(0, '0, 32'h66666666, 0);
    resetn = 1'b1;
    cycle(0, '0, 32'h0, 0);
    chk("rst_valid", 70'(seen_v), 70'(0));
    chk("rst_wr", 70'(seen_wr), 70'(0));
    chk("rst_allow", 70'(seen_allow), 70'(1));
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      b = rand_bundle();
      resetn = $urandom_range(0, 199) != 0;
      cycle(1'($urandom_range(0, 3) != 0), b, $urandom, 1'($urandom_range(0, 2) != 0));
    end
    resetn = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
